// File: rtl/chip_test_sequencer.sv
// chip_test_sequencer
//
// Top-level controller for the chip checker. One DUT socket is shared
// between N_TESTERS tester blocks. A rising edge on Run latches Sel, drives
// the socket pin-mux select, waits SETTLE_CYC cycles for the mux to settle,
// then raises the selected tester's Run line and supervises it with a
// TIMEOUT_CYC watchdog. The result is held until a rising edge on Ack.
//
// Optional build macro: CHIP_SWEEP_EN
//   When defined, adds input Sweep and output Pass_Map. A Run edge with
//   Sweep=1 tests every tester in turn. Each test finishes with a one-cycle
//   Tester_Disp pulse. RESULT then reports the AND of all passes, and
//   Timeout reports the OR of all timeouts.
//
// Ports
//   Clk          system clock
//   Reset        asynchronous active-high reset
//   Run          user start (rising edge starts a test)
//   Ack          user acknowledge (rising edge releases the result)
//   Sel          chip-select code, sampled on the Run edge
//   Tester_Sel   registered socket pin-mux select
//   Tester_Run   one-hot Run to the testers
//   Tester_Done  Done from each tester
//   Tester_RSLT  RSLT from each tester (1 = pass)
//   Tester_Disp  one-hot DISP_RSLT to the testers
//   Busy         test in progress
//   Done         result valid
//   RSLT         1 = pass
//   Timeout      failure caused by the watchdog
//   Bad_Sel      failure caused by Sel >= N_TESTERS
//   Sweep        (CHIP_SWEEP_EN) run all testers back to back
//   Pass_Map     (CHIP_SWEEP_EN) per-tester pass bits from the last sweep

module chip_test_sequencer #(
    parameter int N_TESTERS   = 4,
    parameter int SEL_W       = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic                 Ack,
    input  logic [SEL_W-1:0]     Sel,
`ifdef CHIP_SWEEP_EN
    input  logic                 Sweep,
    output logic [N_TESTERS-1:0] Pass_Map,
`endif
    output logic [SEL_W-1:0]     Tester_Sel,
    output logic [N_TESTERS-1:0] Tester_Run,
    input  logic [N_TESTERS-1:0] Tester_Done,
    input  logic [N_TESTERS-1:0] Tester_RSLT,
    output logic [N_TESTERS-1:0] Tester_Disp,
    output logic                 Busy,
    output logic                 Done,
    output logic                 RSLT,
    output logic                 Timeout,
    output logic                 Bad_Sel
);

    // One counter serves both the settle delay and the watchdog, so it is
    // sized for the larger terminal count.
    localparam int MAX_CYC = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [SEL_W-1:0] LAST_SEL     = SEL_W'(N_TESTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_RUN,
        S_WAIT,
        S_RESULT,
        S_SWDISP
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [SEL_W-1:0]     cur_sel, cur_sel_nx;
    logic [SEL_W-1:0]     tsel_nx;
    logic [N_TESTERS-1:0] trun_nx, tdisp_nx;
    logic                 rslt_nx, tmo_nx, bad_nx;
    logic                 run_q, ack_q;

`ifdef CHIP_SWEEP_EN
    logic                 sweep_r, sweep_nx;
    logic [N_TESTERS-1:0] pmap_nx;
    logic                 tmo_acc, tmo_acc_nx;
`endif

    logic                 run_edge, ack_edge;
    logic                 sel_ok;
    logic [N_TESTERS-1:0] sel_onehot;
    logic                 done_hit, rslt_hit;

    assign run_edge = Run & ~run_q;
    assign ack_edge = Ack & ~ack_q;
    assign sel_ok   = (int'(Sel) < N_TESTERS);

    // Decode of the latched select; masking with it keeps Done/RSLT from
    // non-selected testers out of the FSM.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_TESTERS; i++) begin
            sel_onehot[i] = (cur_sel == SEL_W'(i));
        end
    end

    assign done_hit = |(Tester_Done & sel_onehot);
    assign rslt_hit = |(Tester_RSLT & sel_onehot);

    assign Busy = (state == S_SETTLE) || (state == S_RUN) ||
                  (state == S_WAIT)   || (state == S_SWDISP);
    assign Done = (state == S_RESULT);

    // State and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cur_sel     <= '0;
            run_q       <= 1'b0;
            ack_q       <= 1'b0;
            Tester_Sel  <= '0;
            Tester_Run  <= '0;
            Tester_Disp <= '0;
            RSLT        <= 1'b0;
            Timeout     <= 1'b0;
            Bad_Sel     <= 1'b0;
`ifdef CHIP_SWEEP_EN
            sweep_r     <= 1'b0;
            Pass_Map    <= '0;
            tmo_acc     <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            cur_sel     <= cur_sel_nx;
            run_q       <= Run;
            ack_q       <= Ack;
            Tester_Sel  <= tsel_nx;
            Tester_Run  <= trun_nx;
            Tester_Disp <= tdisp_nx;
            RSLT        <= rslt_nx;
            Timeout     <= tmo_nx;
            Bad_Sel     <= bad_nx;
`ifdef CHIP_SWEEP_EN
            sweep_r     <= sweep_nx;
            Pass_Map    <= pmap_nx;
            tmo_acc     <= tmo_acc_nx;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        cur_sel_nx = cur_sel;
        tsel_nx    = Tester_Sel;
        trun_nx    = Tester_Run;
        tdisp_nx   = Tester_Disp;
        rslt_nx    = RSLT;
        tmo_nx     = Timeout;
        bad_nx     = Bad_Sel;
`ifdef CHIP_SWEEP_EN
        sweep_nx   = sweep_r;
        pmap_nx    = Pass_Map;
        tmo_acc_nx = tmo_acc;
`endif

        case (state)
            S_IDLE: begin
                if (run_edge) begin
                    cnt_nx = '0;
`ifdef CHIP_SWEEP_EN
                    if (Sweep) begin
                        sweep_nx   = 1'b1;
                        pmap_nx    = '0;
                        tmo_acc_nx = 1'b0;
                        cur_sel_nx = '0;
                        tsel_nx    = '0;
                        state_nx   = S_SETTLE;
                    end else
`endif
                    begin
                        cur_sel_nx = Sel;
                        tsel_nx    = Sel;
                        if (!sel_ok) begin
                            // No tester behind this code: fail without touching Run/Disp.
                            bad_nx   = 1'b1;
                            rslt_nx  = 1'b0;
                            state_nx = S_RESULT;
                        end else begin
                            state_nx = S_SETTLE;
                        end
                    end
                end
            end

            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nx = S_RUN;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

            S_RUN: begin
                trun_nx  = sel_onehot;
                cnt_nx   = '0;
                state_nx = S_WAIT;
            end

            S_WAIT: begin
                // A Done in the terminal-count cycle still counts as a real result.
                if (done_hit || (cnt == TIMEOUT_LAST)) begin
                    trun_nx  = '0;
                    tdisp_nx = sel_onehot;
`ifdef CHIP_SWEEP_EN
                    if (sweep_r) begin
                        if (done_hit && rslt_hit) begin
                            pmap_nx = Pass_Map | sel_onehot;
                        end
                        tmo_acc_nx = tmo_acc | ~done_hit;
                        state_nx   = S_SWDISP;
                    end else
`endif
                    begin
                        rslt_nx  = done_hit & rslt_hit;
                        tmo_nx   = ~done_hit;
                        state_nx = S_RESULT;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end

`ifdef CHIP_SWEEP_EN
            S_SWDISP: begin
                // One-cycle display pulse, then either the next tester or the summary.
                tdisp_nx = '0;
                cnt_nx   = '0;
                if (cur_sel == LAST_SEL) begin
                    rslt_nx  = &Pass_Map;
                    tmo_nx   = tmo_acc;
                    state_nx = S_RESULT;
                end else begin
                    cur_sel_nx = cur_sel + SEL_W'(1);
                    tsel_nx    = cur_sel + SEL_W'(1);
                    state_nx   = S_SETTLE;
                end
            end
`endif

            S_RESULT: begin
                if (ack_edge) begin
                    rslt_nx  = 1'b0;
                    tmo_nx   = 1'b0;
                    bad_nx   = 1'b0;
                    tdisp_nx = '0;
`ifdef CHIP_SWEEP_EN
                    sweep_nx = 1'b0;
`endif
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Self-checking bench for chip_test_sequencer.
// dut_a: 4 testers, SETTLE_CYC=16, TIMEOUT_CYC=100 (table-driven vectors).
// dut_b: 3 testers, SETTLE_CYC=4 (bad-select corner case).
module tb_chip_test_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // dut_a
    logic       run_a, ack_a;
    logic [1:0] sel_a;
    logic [3:0] tdone_a, trslt_a;
    logic [1:0] tsel_a;
    logic [3:0] trun_a, tdisp_a;
    logic       busy_a, done_a, rslt_a, tmo_a, bad_a;
`ifdef CHIP_SWEEP_EN
    logic       sweep_a;
    logic [3:0] pmap_a;
    logic       sweep_b;
    logic [2:0] pmap_b;
`endif

    // dut_b
    logic       run_b, ack_b;
    logic [1:0] sel_b;
    logic [2:0] tdone_b, trslt_b;
    logic [1:0] tsel_b;
    logic [2:0] trun_b, tdisp_b;
    logic       busy_b, done_b, rslt_b, tmo_b, bad_b;

    chip_test_sequencer #(
        .N_TESTERS(4), .SEL_W(2), .SETTLE_CYC(16), .TIMEOUT_CYC(100)
    ) dut_a (
        .Clk(clk), .Reset(reset), .Run(run_a), .Ack(ack_a), .Sel(sel_a),
`ifdef CHIP_SWEEP_EN
        .Sweep(sweep_a), .Pass_Map(pmap_a),
`endif
        .Tester_Sel(tsel_a), .Tester_Run(trun_a), .Tester_Done(tdone_a),
        .Tester_RSLT(trslt_a), .Tester_Disp(tdisp_a), .Busy(busy_a),
        .Done(done_a), .RSLT(rslt_a), .Timeout(tmo_a), .Bad_Sel(bad_a)
    );

    chip_test_sequencer #(
        .N_TESTERS(3), .SEL_W(2), .SETTLE_CYC(4), .TIMEOUT_CYC(100)
    ) dut_b (
        .Clk(clk), .Reset(reset), .Run(run_b), .Ack(ack_b), .Sel(sel_b),
`ifdef CHIP_SWEEP_EN
        .Sweep(sweep_b), .Pass_Map(pmap_b),
`endif
        .Tester_Sel(tsel_b), .Tester_Run(trun_b), .Tester_Done(tdone_b),
        .Tester_RSLT(trslt_b), .Tester_Disp(tdisp_b), .Busy(busy_b),
        .Done(done_b), .RSLT(rslt_b), .Timeout(tmo_b), .Bad_Sel(bad_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Expected flags packed as {busy, done, rslt, tmo, bad}.
    typedef struct {
        int         cyc;
        logic       run;
        logic       ack;
        logic [1:0] sel;
        logic [3:0] tdone;
        logic [3:0] trslt;
        logic [4:0] flags;
        logic [1:0] tsel;
        logic [3:0] trun;
        logic [3:0] tdisp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int cyc, input logic run, input logic ack,
                                input logic [1:0] sel, input logic [3:0] tdone,
                                input logic [3:0] trslt, input logic [4:0] flags,
                                input logic [1:0] tsel, input logic [3:0] trun,
                                input logic [3:0] tdisp);
        vec_t v;
        v.cyc = cyc; v.run = run; v.ack = ack; v.sel = sel;
        v.tdone = tdone; v.trslt = trslt; v.flags = flags;
        v.tsel = tsel; v.trun = trun; v.tdisp = tdisp;
        return v;
    endfunction

    task automatic chk_a(input string name, input logic [4:0] flags, input logic [1:0] tsel,
                         input logic [3:0] trun, input logic [3:0] tdisp);
        logic [14:0] got, exp;
        got = {busy_a, done_a, rslt_a, tmo_a, bad_a, tsel_a, trun_a, tdisp_a};
        exp = {flags, tsel, trun, tdisp};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got busy/done/rslt/tmo/bad=%b tsel=%0d trun=%b tdisp=%b; want %b tsel=%0d trun=%b tdisp=%b",
                     name, got[14:10], got[9:8], got[7:4], got[3:0], flags, tsel, trun, tdisp);
        end
    endtask

    task automatic chk_b(input string name, input logic [4:0] flags, input logic [1:0] tsel,
                         input logic [2:0] trun, input logic [2:0] tdisp);
        logic [12:0] got, exp;
        got = {busy_b, done_b, rslt_b, tmo_b, bad_b, tsel_b, trun_b, tdisp_b};
        exp = {flags, tsel, trun, tdisp};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got busy/done/rslt/tmo/bad=%b tsel=%0d trun=%b tdisp=%b; want %b tsel=%0d trun=%b tdisp=%b",
                     name, got[12:8], got[7:6], got[5:3], got[2:0], flags, tsel, trun, tdisp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        run_a = 0; ack_a = 0; sel_a = 0; tdone_a = 0; trslt_a = 0;
        run_b = 0; ack_b = 0; sel_b = 0; tdone_b = 0; trslt_b = 0;
`ifdef CHIP_SWEEP_EN
        sweep_a = 0; sweep_b = 0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_a("reset_a", 5'b00000, 2'd0, 4'b0000, 4'b0000);
        chk_b("reset_b", 5'b00000, 2'd0, 3'b000, 3'b000);
        reset = 0;

        //        cyc run ack sel tdone    trslt    flags     tsel trun     tdisp
        // idle
        vecs.push_back(mk(1,  1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 5'b00000, 2'd0, 4'b0000, 4'b0000));
        // basic pass, Sel=1
        vecs.push_back(mk(1,  1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000, 5'b10000, 2'd1, 4'b0000, 4'b0000));
        vecs.push_back(mk(16, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000, 5'b10000, 2'd1, 4'b0000, 4'b0000));
        vecs.push_back(mk(1,  1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000, 5'b10000, 2'd1, 4'b0010, 4'b0000));
        vecs.push_back(mk(11, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000, 5'b10000, 2'd1, 4'b0010, 4'b0000));
        vecs.push_back(mk(1,  1'b1, 1'b0, 2'd1, 4'b0010, 4'b0010, 5'b01100, 2'd1, 4'b0000, 4'b0010));
        vecs.push_back(mk(3,  1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000, 5'b01100, 2'd1, 4'b0000, 4'b0010));
        vecs.push_back(mk(1,  1'b1, 1'b1, 2'd1, 4'b0000, 4'b0000, 5'b00000, 2'd1, 4'b0000, 4'b0000));
        vecs.push_back(mk(2,  1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 5'b00000, 2'd1, 4'b0000, 4'b0000));
        // fail with noise, Sel=2; Sel changes in SETTLE, Run/Ack edges in WAIT, tester 0 Done
        vecs.push_back(mk(1,  1'b1, 1'b0, 2'd2, 4'b0000, 4'b0000, 5'b10000, 2'd2, 4'b0000, 4'b0000));
        vecs.push_back(mk(17, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000, 5'b10000, 2'd2, 4'b0100, 4'b0000));
        vecs.push_back(mk(1,  1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 5'b10000, 2'd2, 4'b0100, 4'b0000));
        vecs.push_back(mk(1,  1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000, 5'b10000, 2'd2, 4'b0100, 4'b0000));
        vecs.push_back(mk(2,  1'b1, 1'b0, 2'd3, 4'b0001, 4'b0001, 5'b10000, 2'd2, 4'b0100, 4'b0000));
        vecs.push_back(mk(1,  1'b1, 1'b0, 2'd3, 4'b0100, 4'b0000, 5'b01000, 2'd2, 4'b0000, 4'b0100));
        vecs.push_back(mk(1,  1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000, 5'b00000, 2'd2, 4'b0000, 4'b0000));
        vecs.push_back(mk(1,  1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 5'b00000, 2'd2, 4'b0000, 4'b0000));
        // timeout, Sel=3: still waiting at 99 cycles after WAIT entry, RESULT at 100
        vecs.push_back(mk(1,  1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000, 5'b10000, 2'd3, 4'b0000, 4'b0000));
        vecs.push_back(mk(17, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000, 5'b10000, 2'd3, 4'b1000, 4'b0000));
        vecs.push_back(mk(99, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000, 5'b10000, 2'd3, 4'b1000, 4'b0000));
        vecs.push_back(mk(1,  1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000, 5'b01010, 2'd3, 4'b0000, 4'b1000));
        vecs.push_back(mk(1,  1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000, 5'b00000, 2'd3, 4'b0000, 4'b0000));
        vecs.push_back(mk(1,  1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 5'b00000, 2'd3, 4'b0000, 4'b0000));
        // Done in the terminal-count cycle, Sel=0: Done wins
        vecs.push_back(mk(1,  1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 5'b10000, 2'd0, 4'b0000, 4'b0000));
        vecs.push_back(mk(17, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 5'b10000, 2'd0, 4'b0001, 4'b0000));
        vecs.push_back(mk(99, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 5'b10000, 2'd0, 4'b0001, 4'b0000));
        vecs.push_back(mk(1,  1'b1, 1'b0, 2'd0, 4'b0001, 4'b0001, 5'b01100, 2'd0, 4'b0000, 4'b0001));
        vecs.push_back(mk(1,  1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 5'b00000, 2'd0, 4'b0000, 4'b0000));
        vecs.push_back(mk(1,  1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 5'b00000, 2'd0, 4'b0000, 4'b0000));

        for (int i = 0; i < vecs.size(); i++) begin
            run_a = vecs[i].run; ack_a = vecs[i].ack; sel_a = vecs[i].sel;
            tdone_a = vecs[i].tdone; trslt_a = vecs[i].trslt;
            repeat (vecs[i].cyc) @(posedge clk);
            @(negedge clk);
            chk_a($sformatf("vec%0d", i), vecs[i].flags, vecs[i].tsel, vecs[i].trun, vecs[i].tdisp);
        end

        // Reset mid-WAIT clears everything without a clock edge
        run_a = 1; sel_a = 2'd1;
        repeat (18) @(posedge clk);
        @(negedge clk);
        chk_a("pre_reset_wait", 5'b10000, 2'd1, 4'b0010, 4'b0000);
        #2 reset = 1;
        #1 chk_a("async_reset", 5'b00000, 2'd0, 4'b0000, 4'b0000);
        run_a = 0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        run_a = 1; sel_a = 2'd2;
        repeat (18) @(posedge clk);
        @(negedge clk);
        chk_a("after_reset_run", 5'b10000, 2'd2, 4'b0100, 4'b0000);
        tdone_a = 4'b0100; trslt_a = 4'b0100;
        @(posedge clk); @(negedge clk);
        chk_a("after_reset_pass", 5'b01100, 2'd2, 4'b0000, 4'b0100);
        tdone_a = 0; trslt_a = 0; ack_a = 1; run_a = 0;
        @(posedge clk); @(negedge clk);
        chk_a("after_reset_ack", 5'b00000, 2'd2, 4'b0000, 4'b0000);
        ack_a = 0;

        // Bad select on the 3-tester instance
        run_b = 1; sel_b = 2'd3;
        @(posedge clk); @(negedge clk);
        chk_b("bad_sel", 5'b01001, 2'd3, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_b("bad_sel_hold", 5'b01001, 2'd3, 3'b000, 3'b000);
        end
        ack_b = 1; run_b = 0;
        @(posedge clk); @(negedge clk);
        chk_b("bad_sel_ack", 5'b00000, 2'd3, 3'b000, 3'b000);
        ack_b = 0;
        @(negedge clk);
        run_b = 1; sel_b = 2'd2;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk_b("b_run_latency", 5'b10000, 2'd2, 3'b100, 3'b000);
        tdone_b = 3'b100; trslt_b = 3'b000;
        @(posedge clk); @(negedge clk);
        chk_b("b_fail", 5'b01000, 2'd2, 3'b000, 3'b100);
        tdone_b = 0; ack_b = 1; run_b = 0;
        @(posedge clk); @(negedge clk);
        chk_b("b_ack", 5'b00000, 2'd2, 3'b000, 3'b000);
        ack_b = 0;

`ifdef CHIP_SWEEP_EN
        begin
            logic [3:0] pat;
            int         w;
            pat = 4'b1011;
            @(negedge clk);
            sweep_a = 1; run_a = 1; sel_a = 2'd2;
            for (int t = 0; t < 4; t++) begin
                w = 0;
                while (trun_a[t] !== 1'b1 && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                n_vec++;
                if (trun_a[t] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sweep_run%0d: got trun=%b, want bit %0d set", t, trun_a, t);
                end
                tdone_a[t] = 1'b1; trslt_a[t] = pat[t];
                @(negedge clk);
                tdone_a = 0; trslt_a = 0;
            end
            w = 0;
            while (done_a !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            n_vec++;
            if ({pmap_a, done_a, rslt_a, tmo_a} !== {4'b1011, 1'b1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL sweep_result: got pmap=%b done=%b rslt=%b tmo=%b; want 1011 1 0 0",
                         pmap_a, done_a, rslt_a, tmo_a);
            end
            sweep_a = 0; run_a = 0; ack_a = 1;
            @(negedge clk);
            ack_a = 0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
